// File: rtl/tagged_mem_model.sv
// tagged_mem_model: multi-channel tagged word memory for the tag-cache bench.
// Requests from NCH channels are granted round-robin, one per cycle. Each
// granted access reaches its channel's response FIFO LAT cycles later.
// A per-channel credit counter covers both the latency pipe and the FIFO.
module tagged_mem_model #(
    parameter int NCH        = 2,
    parameter int DEPTH      = 256,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 4,
    parameter int ID_W       = 4,
    parameter int LAT        = 2,
    parameter int RESP_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int MW        = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NCH-1:0]        req_valid,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH-1:0]        req_we,
    input  logic [NCH*AW-1:0]     req_addr,
    input  logic [NCH*DATA_W-1:0] req_wdata,
    input  logic [NCH*MW-1:0]     req_wmask,
    input  logic [NCH-1:0]        req_wtag_en,
    input  logic [NCH*TAG_W-1:0]  req_wtag,
    input  logic [NCH*ID_W-1:0]   req_id,
    output logic [NCH-1:0]        resp_valid,
    input  logic [NCH-1:0]        resp_ready,
    output logic [NCH-1:0]        resp_we,
    output logic [NCH*DATA_W-1:0] resp_rdata,
    output logic [NCH*TAG_W-1:0]  resp_rtag,
    output logic [NCH*ID_W-1:0]   resp_id
);
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CRW    = $clog2(RESP_DEPTH + 1);
    localparam int PW     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int PIPE_N = (LAT > 1) ? LAT - 1 : 1;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] rdata;
        logic [TAG_W-1:0]  rtag;
        logic [ID_W-1:0]   id;
    } rsp_t;

    typedef struct packed {
        logic           vld;
        logic [CHW-1:0] ch;
        rsp_t           rsp;
    } pipe_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [TAG_W-1:0]  tag_d [DEPTH];
    logic [CHW-1:0]    rr_q, rr_d;
    logic [CRW-1:0]    credit_q [NCH];
    logic [CRW-1:0]    credit_d [NCH];
    pipe_t             pipe_q [PIPE_N];
    pipe_t             pipe_d [PIPE_N];
    rsp_t              fifo_q [NCH][RESP_DEPTH];
    rsp_t              fifo_d [NCH][RESP_DEPTH];
    logic [PW-1:0]     wptr_q [NCH];
    logic [PW-1:0]     wptr_d [NCH];
    logic [PW-1:0]     rptr_q [NCH];
    logic [PW-1:0]     rptr_d [NCH];
    logic [CRW-1:0]    cnt_q [NCH];
    logic [CRW-1:0]    cnt_d [NCH];

    logic [NCH-1:0]    elig;
    logic [NCH-1:0]    push_c;
    logic [NCH-1:0]    pop_c;
    logic [CHW-1:0]    win;
    logic              found;
    int                arb_idx;
    logic [AW-1:0]     gaddr;
    logic              gwe;
    pipe_t             stage [LAT];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A channel may compete only while it still holds a free response credit
    always_comb begin
        elig = '0;
        for (int c = 0; c < NCH; c++) begin
            elig[c] = rstn && req_valid[c] && (credit_q[c] < CRW'(RESP_DEPTH));
        end
    end

    // Round-robin search beginning one channel past the previous winner
    always_comb begin
        win     = rr_q;
        found   = 1'b0;
        arb_idx = 0;
        for (int k = 1; k <= NCH; k++) begin
            arb_idx = (int'(rr_q) + k) % NCH;
            if (!found && elig[arb_idx]) begin
                found = 1'b1;
                win   = CHW'(arb_idx);
            end
        end
    end

    assign req_ready = found ? (NCH'(1) << win) : '0;

    // Perform the granted access and advance the latency pipe
    always_comb begin
        gaddr = req_addr[int'(win)*AW +: AW];
        gwe   = req_we[win];
        mem_d = mem_q;
        tag_d = tag_q;
        stage[0].vld       = found;
        stage[0].ch        = win;
        stage[0].rsp.we    = gwe;
        stage[0].rsp.rdata = gwe ? '0 : mem_q[gaddr];
        stage[0].rsp.rtag  = gwe ? '0 : tag_q[gaddr];
        stage[0].rsp.id    = req_id[int'(win)*ID_W +: ID_W];
        if (found && gwe) begin
            for (int i = 0; i < MW; i++) begin
                if (req_wmask[int'(win)*MW + i]) begin
                    mem_d[gaddr][i*8 +: 8] = req_wdata[int'(win)*DATA_W + i*8 +: 8];
                end
            end
            if (req_wtag_en[win]) begin
                tag_d[gaddr] = req_wtag[int'(win)*TAG_W +: TAG_W];
            end
        end
        for (int k = 1; k < LAT; k++) begin
            stage[k] = pipe_q[k-1];
        end
        for (int k = 0; k < PIPE_N; k++) begin
            pipe_d[k] = (LAT > 1) ? stage[k] : '0;
        end
    end

    // Push pipe exits into channel FIFOs, pop on handshake, track credits
    always_comb begin
        fifo_d   = fifo_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        credit_d = credit_q;
        push_c   = '0;
        pop_c    = '0;
        for (int c = 0; c < NCH; c++) begin
            push_c[c] = stage[LAT-1].vld && (stage[LAT-1].ch == CHW'(c));
            pop_c[c]  = (cnt_q[c] != '0) && resp_ready[c];
            if (push_c[c]) begin
                fifo_d[c][wptr_q[c]] = stage[LAT-1].rsp;
                wptr_d[c]            = ptr_inc(wptr_q[c]);
            end
            if (pop_c[c]) begin
                rptr_d[c] = ptr_inc(rptr_q[c]);
            end
            if (push_c[c] && !pop_c[c]) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end else if (!push_c[c] && pop_c[c]) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end
            if (req_ready[c] && !pop_c[c]) begin
                credit_d[c] = credit_q[c] + 1'b1;
            end else if (!req_ready[c] && pop_c[c]) begin
                credit_d[c] = credit_q[c] - 1'b1;
            end
        end
        rr_d = found ? win : rr_q;
    end

    // Present each FIFO head; fields read as zero while the FIFO is empty
    always_comb begin
        resp_valid = '0;
        resp_we    = '0;
        resp_rdata = '0;
        resp_rtag  = '0;
        resp_id    = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cnt_q[c] != '0) begin
                resp_valid[c]                  = 1'b1;
                resp_we[c]                     = fifo_q[c][rptr_q[c]].we;
                resp_rdata[c*DATA_W +: DATA_W] = fifo_q[c][rptr_q[c]].rdata;
                resp_rtag[c*TAG_W +: TAG_W]    = fifo_q[c][rptr_q[c]].rtag;
                resp_id[c*ID_W +: ID_W]        = fifo_q[c][rptr_q[c]].id;
            end
        end
    end

    // State update; reset clears storage and discards everything in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                tag_q[i] <= '0;
            end
            rr_q <= CHW'(NCH - 1);
            for (int k = 0; k < PIPE_N; k++) begin
                pipe_q[k] <= '0;
            end
            for (int c = 0; c < NCH; c++) begin
                credit_q[c] <= '0;
                wptr_q[c]   <= '0;
                rptr_q[c]   <= '0;
                cnt_q[c]    <= '0;
                for (int j = 0; j < RESP_DEPTH; j++) begin
                    fifo_q[c][j] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            tag_q    <= tag_d;
            rr_q     <= rr_d;
            pipe_q   <= pipe_d;
            credit_q <= credit_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            fifo_q   <= fifo_d;
        end
    end

    a_onehot_grant: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));

    for (genvar g = 0; g < NCH; g++) begin : g_chk
        a_credit_limit: assert property (@(posedge clk) disable iff (!rstn)
            !(req_ready[g] && credit_q[g] == CRW'(RESP_DEPTH)));
        a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
            !(push_c[g] && cnt_q[g] == CRW'(RESP_DEPTH)));
    end

endmodule

// File: tb/tb_tagged_mem_model.sv
// Bench for tagged_mem_model: directed vector table, multi-cycle sequences and
// random traffic, all checked every cycle against a transaction-level model.
module tb_tagged_mem_model;
    localparam int NCH = 2, DEPTH = 256, DATA_W = 64, TAG_W = 4, ID_W = 4;
    localparam int LAT = 2, RESP_DEPTH = 4, AW = 8, MW = 8;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NCH-1:0]        req_valid, req_ready, req_we, req_wtag_en;
    logic [NCH*AW-1:0]     req_addr;
    logic [NCH*DATA_W-1:0] req_wdata;
    logic [NCH*MW-1:0]     req_wmask;
    logic [NCH*TAG_W-1:0]  req_wtag;
    logic [NCH*ID_W-1:0]   req_id;
    logic [NCH-1:0]        resp_valid, resp_ready, resp_we;
    logic [NCH*DATA_W-1:0] resp_rdata;
    logic [NCH*TAG_W-1:0]  resp_rtag;
    logic [NCH*ID_W-1:0]   resp_id;

    tagged_mem_model #(.NCH(NCH), .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
                       .ID_W(ID_W), .LAT(LAT), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .req_wtag_en(req_wtag_en), .req_wtag(req_wtag),
        .req_id(req_id), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_we(resp_we), .resp_rdata(resp_rdata), .resp_rtag(resp_rtag),
        .resp_id(resp_id));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: storage plus per-channel list of outstanding responses
    typedef struct packed {
        int                rdy;
        logic              we;
        logic [DATA_W-1:0] d;
        logic [TAG_W-1:0]  t;
        logic [ID_W-1:0]   id;
    } mrsp_t;
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [TAG_W-1:0]  m_tag [DEPTH];
    mrsp_t             m_q [NCH][RESP_DEPTH];
    int                m_hd [NCH];
    int                m_n [NCH];
    int                m_last;

    // values seen during the most recent step
    logic [NCH-1:0]        s_ready, s_rvalid, s_rwe;
    logic [NCH*DATA_W-1:0] s_rdata;
    logic [NCH*TAG_W-1:0]  s_rtag;
    logic [NCH*ID_W-1:0]   s_rid;
    int                    s_cyc;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        wtag_en;
        logic [3:0]  wtag;
        logic [3:0]  id;
        logic [63:0] exp_rdata;
        logic [3:0]  exp_rtag;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_tag[i] = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            m_hd[c] = 0;
            m_n[c]  = 0;
        end
        m_last = NCH - 1;
    endtask

    task automatic set_req(input int c, input logic we, input logic [AW-1:0] a,
                           input logic [63:0] d, input logic [7:0] m, input logic te,
                           input logic [3:0] t, input logic [3:0] id);
        req_we[c]                     = we;
        req_addr[c*AW +: AW]          = a;
        req_wdata[c*DATA_W +: DATA_W] = d;
        req_wmask[c*MW +: MW]         = m;
        req_wtag_en[c]                = te;
        req_wtag[c*TAG_W +: TAG_W]    = t;
        req_id[c*ID_W +: ID_W]        = id;
    endtask

    // One clock: called just after a falling edge with inputs applied.
    task automatic step();
        logic [NCH-1:0] exp_rdy, exp_v;
        int             win, a, slot;
        mrsp_t          h, e;
        #1;
        exp_rdy = '0;
        exp_v   = '0;
        win     = -1;
        if (!rstn) m_clear();
        else begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (win < 0 && req_valid[c] && m_n[c] < RESP_DEPTH) win = c;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int c = 0; c < NCH; c++) begin
            h = '0;
            if (rstn && m_n[c] > 0 && m_q[c][m_hd[c]].rdy <= cyc) begin
                exp_v[c] = 1'b1;
                h        = m_q[c][m_hd[c]];
            end
            chk($sformatf("resp_valid%0d", c), 64'(resp_valid[c]), 64'(exp_v[c]));
            chk($sformatf("resp_we%0d", c), 64'(resp_we[c]), 64'(h.we));
            chk($sformatf("resp_rdata%0d", c), resp_rdata[c*DATA_W +: DATA_W], h.d);
            chk($sformatf("resp_rtag%0d", c), 64'(resp_rtag[c*TAG_W +: TAG_W]), 64'(h.t));
            chk($sformatf("resp_id%0d", c), 64'(resp_id[c*ID_W +: ID_W]), 64'(h.id));
        end
        s_ready = req_ready;  s_rvalid = resp_valid; s_rwe = resp_we;
        s_rdata = resp_rdata; s_rtag = resp_rtag;    s_rid = resp_id;
        s_cyc   = cyc;
        for (int c = 0; c < NCH; c++) begin
            if (exp_v[c] && resp_ready[c]) begin
                m_hd[c] = (m_hd[c] + 1) % RESP_DEPTH;
                m_n[c]--;
            end
        end
        if (win >= 0) begin
            a     = int'(req_addr[win*AW +: AW]);
            e.rdy = cyc + LAT;
            e.we  = req_we[win];
            e.d   = req_we[win] ? '0 : m_mem[a];
            e.t   = req_we[win] ? '0 : m_tag[a];
            e.id  = req_id[win*ID_W +: ID_W];
            slot  = (m_hd[win] + m_n[win]) % RESP_DEPTH;
            m_q[win][slot] = e;
            m_n[win]++;
            if (req_we[win]) begin
                for (int i = 0; i < MW; i++)
                    if (req_wmask[win*MW + i]) m_mem[a][i*8 +: 8] = req_wdata[win*DATA_W + i*8 +: 8];
                if (req_wtag_en[win]) m_tag[a] = req_wtag[win*TAG_W +: TAG_W];
            end
            m_last = win;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Issue one transaction on channel 0 and check its response against v.
    task automatic run_vec(input vec_t v, input string nm);
        int g, r;
        logic [63:0] rd;
        logic [3:0]  rt, ri;
        logic        rw;
        g = -1; r = -1; rd = '0; rt = '0; ri = '0; rw = 1'b0;
        resp_ready = '1;
        set_req(0, v.we, v.addr, v.wdata, v.wmask, v.wtag_en, v.wtag, v.id);
        req_valid = 2'b01;
        for (int w = 0; w < 20 && g < 0; w++) begin
            step();
            if (s_ready[0]) g = s_cyc;
        end
        req_valid = '0;
        chk({nm, "_granted"}, 64'(g >= 0), 64'd1);
        for (int w = 0; w < 20 && r < 0; w++) begin
            step();
            if (s_rvalid[0]) begin
                r = s_cyc; rd = s_rdata[63:0]; rt = s_rtag[3:0]; ri = s_rid[3:0]; rw = s_rwe[0];
            end
        end
        chk({nm, "_latency"}, 64'(r - g), 64'(LAT));
        chk({nm, "_we"}, 64'(rw), 64'(v.we));
        chk({nm, "_rdata"}, rd, v.exp_rdata);
        chk({nm, "_rtag"}, 64'(rt), 64'(v.exp_rtag));
        chk({nm, "_id"}, 64'(ri), 64'(v.id));
    endtask

    task automatic do_reset();
        req_valid  = '0;
        resp_ready = '1;
        rstn       = 1'b0;
        step();
        rstn       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gcnt, nid, exp_id, first_pop, first_g, cnt;
        vec_t v;
        //        we    addr  wdata                  mask   ten   tag   id    exp_rdata              exp_tag
        tbl[0] = '{1'b0, 8'd5, 64'h0,                 8'h00, 1'b0, 4'h0, 4'd1, 64'h0,                 4'h0};
        tbl[1] = '{1'b1, 8'd3, 64'h1122334455667788, 8'h0F, 1'b1, 4'hA, 4'd2, 64'h0,                 4'h0};
        tbl[2] = '{1'b0, 8'd3, 64'h0,                 8'h00, 1'b0, 4'h0, 4'd3, 64'h0000000055667788, 4'hA};
        tbl[3] = '{1'b1, 8'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, 4'h5, 4'd4, 64'h0,                 4'h0};
        tbl[4] = '{1'b0, 8'd3, 64'h0,                 8'h00, 1'b0, 4'h0, 4'd5, 64'hDEADBEEFCAFEF00D, 4'hA};
        tbl[5] = '{1'b1, 8'd7, 64'hAABBCCDDEEFF0011, 8'h81, 1'b1, 4'h3, 4'd6, 64'h0,                 4'h0};
        tbl[6] = '{1'b0, 8'd7, 64'h0,                 8'h00, 1'b0, 4'h0, 4'd7, 64'hAA00000000000011, 4'h3};

        rstn = 1'b1; req_valid = '0; resp_ready = '1;
        req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        req_wtag_en = '0; req_wtag = '0; req_id = '0;
        m_clear();
        #2 rstn = 1'b0;
        @(negedge clk);

        // reset holds off grants even with every channel requesting
        req_valid = '1;
        step();
        step();
        chk("t1_ready_in_reset", 64'(s_ready), 64'd0);
        chk("t1_rvalid_in_reset", 64'(s_rvalid), 64'd0);
        req_valid = '0;
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // both channels saturated: grants alternate starting at channel 0
        do_reset();
        set_req(0, 1'b0, 8'd1, 64'h0, 8'h0, 1'b0, 4'h0, 4'd0);
        set_req(1, 1'b0, 8'd2, 64'h0, 8'h0, 1'b0, 4'h0, 4'd0);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t4_grant%0d", i), 64'(s_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        req_valid = '0;
        repeat (6) step();

        // credit stall on channel 1, then release
        do_reset();
        resp_ready = 2'b01;
        gcnt = 0; nid = 0;
        for (int i = 0; i < 12; i++) begin
            set_req(1, 1'b0, AW'(nid), 64'h0, 8'h0, 1'b0, 4'h0, ID_W'(nid));
            req_valid = (nid < 6) ? 2'b10 : 2'b00;
            step();
            if (s_ready[1]) begin gcnt++; nid++; end
        end
        chk("t5_grants_stalled", 64'(gcnt), 64'(RESP_DEPTH));
        chk("t5_ready_low", 64'(s_ready[1]), 64'd0);
        resp_ready = 2'b11;
        exp_id = 0; first_pop = -1; first_g = -1;
        for (int i = 0; i < 30; i++) begin
            set_req(1, 1'b0, AW'(nid), 64'h0, 8'h0, 1'b0, 4'h0, ID_W'(nid));
            req_valid = (nid < 6) ? 2'b10 : 2'b00;
            step();
            if (s_rvalid[1]) begin
                chk($sformatf("t5_id_order%0d", exp_id), 64'(s_rid[ID_W +: ID_W]), 64'(exp_id));
                exp_id++;
                if (first_pop < 0) first_pop = s_cyc;
            end
            if (s_ready[1]) begin
                if (first_g < 0) first_g = s_cyc;
                nid++;
            end
        end
        req_valid = '0;
        chk("t5_resume_delay", 64'(first_g - first_pop), 64'd1);
        chk("t5_resp_count", 64'(exp_id), 64'd6);

        // reset while reads are in flight
        do_reset();
        v = '{1'b1, 8'd9, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 4'h6, 4'd9, 64'h0, 4'h0};
        run_vec(v, "t6_write");
        resp_ready = '0;
        set_req(0, 1'b0, 8'd9, 64'h0, 8'h0, 1'b0, 4'h0, 4'd1);
        set_req(1, 1'b0, 8'd9, 64'h0, 8'h0, 1'b0, 4'h0, 4'd2);
        req_valid = 2'b11;
        repeat (3) step();
        req_valid = '0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        resp_ready = '1;
        cnt = 0;
        repeat (8) begin
            step();
            if (s_rvalid != '0) cnt++;
        end
        chk("t6_no_stale_resp", 64'(cnt), 64'd0);
        resp_ready = '0;
        req_valid = 2'b11;
        gcnt = 0;
        repeat (10) begin
            step();
            gcnt += $countones(s_ready);
        end
        chk("t6_full_credit", 64'(gcnt), 64'(2 * RESP_DEPTH));
        req_valid = '0;
        resp_ready = '1;
        repeat (8) step();
        v = '{1'b0, 8'd9, 64'h0, 8'h00, 1'b0, 4'h0, 4'd3, 64'h0, 4'h0};
        run_vec(v, "t6_cleared");

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                set_req(c, 1'($urandom), AW'($urandom_range(0, 15)), {$urandom, $urandom},
                        8'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
                req_valid[c]  = ($urandom_range(0, 3) != 0);
                resp_ready[c] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        req_valid  = '0;
        resp_ready = '1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
